fp32_accumulator: RTL and testbench

- Downstream consumer of the FP32 pipelined multiplier's product stream F.
- Sums a framed sequence of IEEE-754 single-precision products into a running total. One frame is one dot-product.
- Emits the frame total and term count when the last term is accepted.
- Iterative align/add/normalize FSM with a valid/ready input handshake, so variable latency back-pressures the producer.

---
 rtl/fp32_accumulator.sv | 222 ++++++++++++++++++++++
 tb/tb_fp32_accumulator.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_accumulator.sv
// fp32_accumulator: sums framed FP32 terms with an iterative align/add/normalize FSM.
// Define FP_ACC_NAN_EN to track NaN/Inf per frame instead of treating exp=255 as ordinary.
module fp32_accumulator #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic               out_valid,
  output logic [31:0]        out_data,
  output logic [COUNT_W-1:0] out_count
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [31:0]        acc_q, acc_d, term_q, term_d;
  logic [COUNT_W-1:0] count_q, count_d, out_count_q, out_count_d;
  logic               last_q, last_d, sign_q, sign_d, sub_q, sub_d;
  logic [9:0]         exp_q, exp_d;
  logic [23:0]        big_q, big_d, small_q, small_d;
  logic [24:0]        mant_q, mant_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q, out_data_d;
`ifdef FP_ACC_NAN_EN
  logic               nan_q, nan_d, inf_q, inf_d, inf_sign_q, inf_sign_d;
`endif

  logic [7:0]  a_exp, t_exp, b_exp, s_exp, diff;
  logic [23:0] a_man, t_man, b_man, s_man;
  logic        t_big, b_sign;
  logic [24:0] sum;
  logic [9:0]  fin_exp;
  logic [22:0] fin_man;

  function automatic logic [31:0] pack(input logic s, input logic [9:0] e, input logic [22:0] m);
    if (e >= 10'd255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], m};
  endfunction

  // Operand decode and the combinational halves of ALIGN/ADD/NORM.
  always_comb begin
    a_exp = acc_q[30:23];
    a_man = (a_exp == 8'd0) ? 24'd0 : {1'b1, acc_q[22:0]};
    t_exp = term_q[30:23];
    t_man = (t_exp == 8'd0) ? 24'd0 : {1'b1, term_q[22:0]};
`ifdef FP_ACC_NAN_EN
    if (t_exp == 8'hFF) begin
      t_exp = 8'd0;
      t_man = 24'd0;
    end
`endif
    t_big   = (t_exp > a_exp) || ((t_exp == a_exp) && (t_man > a_man));
    b_exp   = t_big ? t_exp : a_exp;
    s_exp   = t_big ? a_exp : t_exp;
    b_man   = t_big ? t_man : a_man;
    s_man   = t_big ? a_man : t_man;
    b_sign  = t_big ? term_q[31] : acc_q[31];
    diff    = b_exp - s_exp;
    sum     = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
    fin_exp = mant_q[24] ? (exp_q + 10'd1) : exp_q;
    fin_man = mant_q[24] ? mant_q[23:1] : mant_q[22:0];
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    term_d      = term_q;
    count_d     = count_q;
    last_d      = last_q;
    sign_d      = sign_q;
    sub_d       = sub_q;
    exp_d       = exp_q;
    big_d       = big_q;
    small_d     = small_q;
    mant_d      = mant_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
`ifdef FP_ACC_NAN_EN
    nan_d      = nan_q;
    inf_d      = inf_q;
    inf_sign_d = inf_sign_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          term_d  = in_data;
          last_d  = in_last;
          count_d = count_q + 1'b1;
          state_d = S_ALIGN;
`ifdef FP_ACC_NAN_EN
          if (in_data[30:23] == 8'hFF) begin
            if ((in_data[22:0] != 23'd0) || (inf_q && (inf_sign_q != in_data[31]))) nan_d = 1'b1;
            else begin
              inf_d      = 1'b1;
              inf_sign_d = in_data[31];
            end
          end
`endif
        end
      end
      S_ALIGN: begin
        exp_d   = {2'b00, b_exp};
        big_d   = b_man;
        small_d = ((diff >= 8'd25) || (s_man == 24'd0)) ? 24'd0 : (s_man >> diff);
        sign_d  = b_sign;
        sub_d   = acc_q[31] ^ term_q[31];
        state_d = S_ADD;
      end
      S_ADD: begin
        mant_d = sum;
        if (sum == 25'd0) begin
          acc_d   = 32'd0;
          state_d = S_FIN;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        // One left shift per cycle; underflow to exp 0 flushes the result.
        if (!mant_q[24] && !mant_q[23]) begin
          mant_d = {mant_q[23:0], 1'b0};
          exp_d  = exp_q - 10'd1;
          if (exp_q == 10'd1) begin
            acc_d   = 32'd0;
            state_d = S_FIN;
          end
        end else begin
          acc_d   = pack(sign_q, fin_exp, fin_man);
          state_d = S_FIN;
`ifdef FP_ACC_NAN_EN
          if (fin_exp >= 10'd255) begin
            if (inf_q && (inf_sign_q != sign_q)) nan_d = 1'b1;
            else begin
              inf_d      = 1'b1;
              inf_sign_d = sign_q;
            end
          end
`endif
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (last_q) begin
          acc_d   = 32'd0;
          count_d = '0;
`ifdef FP_ACC_NAN_EN
          nan_d      = 1'b0;
          inf_d      = 1'b0;
          inf_sign_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Result registers load on entry to FIN so the pulse lines up with the FIN cycle.
    if ((state_d == S_FIN) && (state_q != S_FIN) && last_q) begin
      out_valid_d = 1'b1;
      out_count_d = count_q;
`ifdef FP_ACC_NAN_EN
      if (nan_d)      out_data_d = 32'h7FC0_0000;
      else if (inf_d) out_data_d = {inf_sign_d, 8'hFF, 23'd0};
      else            out_data_d = acc_d;
`else
      out_data_d = acc_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      acc_q       <= 32'd0;
      count_q     <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_count_q <= '0;
`ifdef FP_ACC_NAN_EN
      nan_q      <= 1'b0;
      inf_q      <= 1'b0;
      inf_sign_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
`ifdef FP_ACC_NAN_EN
      nan_q      <= nan_d;
      inf_q      <= inf_d;
      inf_sign_q <= inf_sign_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    term_q  <= term_d;
    sign_q  <= sign_d;
    sub_q   <= sub_d;
    exp_q   <= exp_d;
    big_q   <= big_d;
    small_q <= small_d;
    mant_q  <= mant_d;
  end

  assign in_ready  = rst && (state_q == S_IDLE);
  assign out_valid = rst && out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
endmodule

// File: tb/tb_fp32_accumulator.sv
// Bench for fp32_accumulator: randomized frames against a value-level FP model plus pinned literals.
module tb_fp32_accumulator;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [31:0]   in_data = 32'd0;
  logic          in_ready, out_valid;
  logic [31:0]   out_data;
  logic [CW-1:0] out_count;

  always #5 clk = ~clk;

  fp32_accumulator #(.COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_data(out_data), .out_count(out_count)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_data_q[$];
  int          exp_cnt_q[$];
  logic [31:0] m_acc = 32'd0;
  int          m_cnt = 0;
  bit          m_nan = 0, m_inf = 0, m_inf_s = 0;
  logic [31:0] last_push_data = 32'd0;
  int          last_push_cnt = 0;
  bit          hold_vld = 0;
  logic [31:0] hold_data = 32'd0;
  int          hold_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Value-level model: real alignment by exponent difference, truncation, normalise by leading one.
  task automatic model_add(input logic [31:0] a, input logic [31:0] t,
                           output logic [31:0] r, output int lat, output bit ovf);
    int ea, et, eb, es, d, e, k;
    longint ma, mt, mb, ms, s;
    bit sb, ss;
    ea = int'(a[30:23]);
    et = int'(t[30:23]);
    ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
    mt = (et == 0) ? 0 : (longint'(1) << 23) + longint'(t[22:0]);
`ifdef FP_ACC_NAN_EN
    if (et == 255) begin et = 0; mt = 0; end
`endif
    ovf = 0;
    if (et > ea || (et == ea && mt > ma)) begin
      eb = et; mb = mt; sb = t[31]; es = ea; ms = ma; ss = a[31];
    end else begin
      eb = ea; mb = ma; sb = a[31]; es = et; ms = mt; ss = t[31];
    end
    d  = eb - es;
    ms = (d >= 25) ? 0 : (ms >> d);
    s  = (sb == ss) ? mb + ms : mb - ms;
    if (s == 0) begin r = 32'd0; lat = 3; return; end
    if (s >= (longint'(1) << 24)) begin
      e = eb + 1; s = s >> 1; lat = 4;
    end else begin
      k = 0;
      while (s < (longint'(1) << 23)) begin s = s << 1; k++; end
      if (eb <= k) begin r = 32'd0; lat = 3 + eb; return; end
      e = eb - k; lat = 4 + k;
    end
    if (e >= 255) begin r = {sb, 8'hFF, 23'd0}; ovf = 1; end
    else          r = {sb, 8'(e), s[22:0]};
  endtask

  task automatic model_reset();
    m_acc = 32'd0; m_cnt = 0; m_nan = 0; m_inf = 0; m_inf_s = 0;
  endtask

  task automatic model_accept(input logic [31:0] t, input bit l, output int lat);
    logic [31:0] r;
    bit ovf;
    m_cnt = (m_cnt + 1) % (1 << CW);
`ifdef FP_ACC_NAN_EN
    if (t[30:23] == 8'hFF) begin
      if (t[22:0] != 0 || (m_inf && m_inf_s != t[31])) m_nan = 1;
      else begin m_inf = 1; m_inf_s = t[31]; end
    end
`endif
    model_add(m_acc, t, r, lat, ovf);
    m_acc = r;
`ifdef FP_ACC_NAN_EN
    if (ovf) begin
      if (m_inf && m_inf_s != r[31]) m_nan = 1;
      else begin m_inf = 1; m_inf_s = r[31]; end
    end
    if (l && m_nan) r = 32'h7FC0_0000;
    else if (l && m_inf) r = {m_inf_s, 8'hFF, 23'd0};
`endif
    if (l) begin
      exp_data_q.push_back(r);
      exp_cnt_q.push_back(m_cnt);
      last_push_data = r;
      last_push_cnt  = m_cnt;
      model_reset();
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready) begin
      @(negedge clk);
      t++;
      if (t > 200) begin
        errors++;
        $display("FAIL ready_timeout: in_ready still 0 after %0d cycles", t);
        $fatal(1, "in_ready never rose");
      end
    end
  endtask

  // Called at a negedge; returns at the negedge where in_ready is high again.
  task automatic send(input logic [31:0] d, input bit l, input int gap);
    int lat_exp, lat;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    wait_ready();
    @(posedge clk);
    model_accept(d, l, lat_exp);
    @(negedge clk);
    in_valid = 1'b0; in_data = $urandom; in_last = 1'($urandom_range(0, 1));
    lat = 0;
    while (!in_ready && lat < 200) begin lat++; @(negedge clk); end
    chk("latency", 32'(lat), 32'(lat_exp));
  endtask

  task automatic do_reset();
    rst = 1'b0; hold_vld = 0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] gen_term(input logic [31:0] acc);
    logic [31:0] r = $urandom;
    int e;
    case ($urandom_range(0, 9))
      0: r[30:23] = 8'd0;
      1, 2, 3: begin
        e = int'(acc[30:23]) + int'($urandom_range(0, 6)) - 3;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        r[30:23] = 8'(e);
      end
      4: if (acc != 0) r = acc ^ 32'h8000_0000;
      5: r[30:23] = 8'($urandom_range(248, 254));
      6: r[30:23] = 8'($urandom_range(1, 4));
      7: if (acc != 0) r = (acc ^ 32'h8000_0000) ^ (32'd1 << $urandom_range(0, 22));
      default: ;
    endcase
    return r;
  endfunction

  // Single compare process: every out_valid is matched to the scoreboard, and outputs hold otherwise.
  initial begin
    logic [31:0] d;
    int c;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_data_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stray_out_valid: out_data=0x%08h out_count=%0d with no frame expected", out_data, out_count);
        end else begin
          d = exp_data_q.pop_front();
          c = exp_cnt_q.pop_front();
          chk("out_data", out_data, d);
          chk("out_count", 32'(out_count), 32'(c));
          hold_vld = 1; hold_data = d; hold_cnt = c;
        end
      end else if (hold_vld && rst) begin
        chk("hold_data", out_data, hold_data);
        chk("hold_count", 32'(out_count), 32'(hold_cnt));
      end
    end
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int lat;
    bit ovf;
    // Pin the model with hand-computed results.
    model_add(32'h3F80_0000, 32'h4000_0000, r, lat, ovf);
    chk("pin_1p2_data", r, 32'h4040_0000); chk("pin_1p2_lat", 32'(lat), 32'd4);
    model_add(32'h4040_0000, 32'hC040_0000, r, lat, ovf);
    chk("pin_cancel_data", r, 32'd0); chk("pin_cancel_lat", 32'(lat), 32'd3);
    model_add(32'h3FC0_0000, 32'hBF80_0000, r, lat, ovf);
    chk("pin_half_data", r, 32'h3F00_0000); chk("pin_half_lat", 32'(lat), 32'd5);
    model_add(32'h3F80_0000, 32'h3080_0000, r, lat, ovf);
    chk("pin_farexp_data", r, 32'h3F80_0000);
    model_add(32'h7F7F_FFFF, 32'h7F7F_FFFF, r, lat, ovf);
    chk("pin_ovf_data", r, 32'h7F80_0000);
    model_add(32'h0080_0001, 32'h8080_0000, r, lat, ovf);
    chk("pin_flush_data", r, 32'd0); chk("pin_flush_lat", 32'(lat), 32'd4);
    model_add(32'd0, 32'h0040_0000, r, lat, ovf);
    chk("pin_denorm_data", r, 32'd0);

    @(negedge clk);
    do_reset();

    send(32'h3F80_0000, 0, 0); send(32'h4000_0000, 1, 0);
    chk("t1_model", last_push_data, 32'h4040_0000);
    send(32'h4040_0000, 0, 1); send(32'hC040_0000, 1, 0);
    chk("t2_model", last_push_data, 32'd0);
    send(32'h3FC0_0000, 0, 0); send(32'hBF80_0000, 1, 2);
    chk("t3_model", last_push_data, 32'h3F00_0000);
    send(32'h3F80_0000, 0, 0); send(32'h3080_0000, 1, 0);
    chk("t4_model", last_push_data, 32'h3F80_0000);
    send(32'h7F7F_FFFF, 0, 0); send(32'h7F7F_FFFF, 1, 0);
    chk("t5_model", last_push_data, 32'h7F80_0000);
    send(32'h0080_0001, 0, 0); send(32'h8080_0000, 1, 0);
    send(32'hBF80_0000, 1, 0);
    chk("single_model", last_push_data, 32'hBF80_0000);
    send(32'h0012_3456, 1, 0);
    chk("single_denorm_model", last_push_data, 32'd0);
`ifdef FP_ACC_NAN_EN
    send(32'h7F80_0000, 0, 0); send(32'hFF80_0000, 1, 0);
    chk("nan_model", last_push_data, 32'h7FC0_0000);
`endif
    for (int i = 0; i < 17; i++) send(32'h3F80_0000, (i == 16), 0);
    chk("wrap_model_data", last_push_data, 32'h4188_0000);
    chk("wrap_model_cnt", 32'(last_push_cnt), 32'd1);

    // Mid-frame reset: two terms accepted, reset lands while the second is in ALIGN.
    send(32'h4080_0000, 0, 0);
    in_valid = 1'b1; in_data = 32'h4100_0000; in_last = 1'b0;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0; hold_vld = 0;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    send(32'h4000_0000, 1, 0);
    chk("midrst_model_data", last_push_data, 32'h4000_0000);
    chk("midrst_model_cnt", 32'(last_push_cnt), 32'd1);

    for (int f = 0; f < 250; f++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) send(gen_term(m_acc), (i == n - 1), $urandom_range(0, 2));
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_data_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
